// File: rtl/jump_pkg.sv
// Shared encodings for the jump/branch predictor: jump class, branch kind and
// 2-bit saturating counter values, plus the counter step helper.
// Pure declarations; no ports.
package jump_pkg;

    typedef enum logic [1:0] {
        J_NONE   = 2'b00,
        J_JAL    = 2'b01,
        J_JALR   = 2'b10,
        J_BRANCH = 2'b11
    } j_type_e;

    typedef enum logic [1:0] {
        BR_BEQ = 2'b00,
        BR_BNE = 2'b01,
        BR_BLT = 2'b10,
        BR_BGE = 2'b11
    } branch_t_e;

    localparam logic [1:0] CTR_SN = 2'b00;
    localparam logic [1:0] CTR_WN = 2'b01;
    localparam logic [1:0] CTR_WT = 2'b10;
    localparam logic [1:0] CTR_ST = 2'b11;

    // Saturating step toward the resolved direction.
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
        end
        return (ctr == CTR_SN) ? CTR_SN : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/branch_resolve.sv
// Resolves the actual direction of the EX-stage control-flow instruction and
// decides whether fetch must be redirected. Purely combinational.
// Ports: EX instruction class/kind/compare flags/target and the piped
// prediction in; taken, mispredict and alias (non-jump predicted taken) out.
module branch_resolve
    import jump_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            valid_i,
    input  logic [1:0]      j_type_i,
    input  logic [1:0]      branch_t_i,
    input  logic            sign_i,
    input  logic            zero_i,
    input  logic [XLEN-1:0] target_i,
    input  logic            pred_taken_i,
    input  logic [XLEN-1:0] pred_target_i,
    output logic            taken_o,
    output logic            mispredict_o,
    output logic            alias_o
);

    logic taken;

    always_comb begin
        taken = 1'b0;
        case (j_type_e'(j_type_i))
            J_JAL, J_JALR: taken = 1'b1;
            J_BRANCH: begin
                case (branch_t_e'(branch_t_i))
                    BR_BEQ: taken = zero_i;
                    BR_BNE: taken = ~zero_i;
                    BR_BLT: taken = sign_i;
                    BR_BGE: taken = ~sign_i;
                    default: taken = 1'b0;
                endcase
            end
            default: taken = 1'b0;
        endcase
    end

    // JALR targets are never trusted from the table, so it always redirects.
    // An alias (non-jump predicted taken) is covered by the direction mismatch.
    assign taken_o      = taken;
    assign mispredict_o = valid_i &&
                          ((taken != pred_taken_i) ||
                           (taken && pred_taken_i && (target_i != pred_target_i)) ||
                           (j_type_i == J_JALR));
    assign alias_o      = valid_i && (j_type_i == J_NONE) && pred_taken_i;

endmodule

// File: rtl/jump_predict_cnt.sv
// Direct-mapped branch target buffer with 2-bit saturating counters plus
// EX-stage redirect logic and resolved/redirect statistics.
// Ports: fetch PC in / prediction out; EX resolution in; flush, next_pc and
// the br_cnt/mis_cnt counters out. Lookup is combinational on registered state.
module jump_predict_cnt
    import jump_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 16,
    parameter int TAG_W  = 8,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [XLEN-1:0]   if_pc,
    output logic              if_pred_taken,
    output logic [XLEN-1:0]   if_pred_target,
    input  logic              ex_valid,
    input  logic [XLEN-1:0]   ex_pc,
    input  logic [XLEN-1:0]   ex_target,
    input  logic [1:0]        ex_j_type,
    input  logic [1:0]        ex_branch_t,
    input  logic              ex_sign,
    input  logic              ex_zero,
    input  logic              ex_pred_taken,
    input  logic [XLEN-1:0]   ex_pred_target,
    output logic              flush,
    output logic [XLEN-1:0]   next_pc,
    output logic [STAT_W-1:0] br_cnt,
    output logic [STAT_W-1:0] mis_cnt
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0] valid_q;
    logic [TAG_W-1:0] tag_q [DEPTH];
    logic [XLEN-1:0]  tgt_q [DEPTH];
    logic [1:0]       ctr_q [DEPTH];
    logic [STAT_W-1:0] br_cnt_q, br_cnt_d;
    logic [STAT_W-1:0] mis_cnt_q, mis_cnt_d;

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0] if_tag, ex_tag;
    logic             ex_hit;
    logic             res_taken, res_mis, res_alias;

    logic             wr_en;
    logic             wr_valid_d;
    logic [TAG_W-1:0] wr_tag_d;
    logic [XLEN-1:0]  wr_tgt_d;
    logic [1:0]       wr_ctr_d;

    // Only the index/tag slices matter for the table; low bits and upper
    // bits of the PCs are otherwise consumed only by the +4 arithmetic.
    logic unused_pc;
    assign unused_pc = ^{if_pc, ex_pc};

    assign if_idx = if_pc[IDX_W+1:2];
    assign if_tag = if_pc[IDX_W+2 +: TAG_W];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign ex_tag = ex_pc[IDX_W+2 +: TAG_W];

    // Registered state only: a write to the same index this cycle is not seen.
    assign if_pred_taken  = valid_q[if_idx] && (tag_q[if_idx] == if_tag) && ctr_q[if_idx][1];
    assign if_pred_target = if_pred_taken ? tgt_q[if_idx] : '0;

    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    branch_resolve #(.XLEN(XLEN)) u_resolve (
        .valid_i       (ex_valid),
        .j_type_i      (ex_j_type),
        .branch_t_i    (ex_branch_t),
        .sign_i        (ex_sign),
        .zero_i        (ex_zero),
        .target_i      (ex_target),
        .pred_taken_i  (ex_pred_taken),
        .pred_target_i (ex_pred_target),
        .taken_o       (res_taken),
        .mispredict_o  (res_mis),
        .alias_o       (res_alias)
    );

    // EX redirect always overrides whatever fetch predicted this cycle.
    always_comb begin
        flush   = res_mis;
        next_pc = if_pred_taken ? if_pred_target : if_pc + XLEN'(4);
        if (res_mis) begin
            next_pc = res_taken ? ex_target : ex_pc + XLEN'(4);
        end
    end

    // Single entry write per cycle, built from the current entry contents.
    always_comb begin
        wr_en      = 1'b0;
        wr_valid_d = valid_q[ex_idx];
        wr_tag_d   = tag_q[ex_idx];
        wr_tgt_d   = tgt_q[ex_idx];
        wr_ctr_d   = ctr_q[ex_idx];
        if (ex_valid) begin
            case (j_type_e'(ex_j_type))
                J_JAL: begin
                    wr_en      = 1'b1;
                    wr_valid_d = 1'b1;
                    wr_tag_d   = ex_tag;
                    wr_tgt_d   = ex_target;
                    wr_ctr_d   = CTR_ST;
                end
                J_BRANCH: begin
                    if (ex_hit) begin
                        wr_en    = 1'b1;
                        wr_ctr_d = ctr_next(ctr_q[ex_idx], res_taken);
                        if (res_taken) begin
                            wr_tgt_d = ex_target;
                        end
                    end else if (res_taken) begin
                        wr_en      = 1'b1;
                        wr_valid_d = 1'b1;
                        wr_tag_d   = ex_tag;
                        wr_tgt_d   = ex_target;
                        wr_ctr_d   = CTR_WT;
                    end
                end
                J_NONE: begin
                    if (res_alias) begin
                        wr_en      = 1'b1;
                        wr_valid_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        br_cnt_d  = br_cnt_q;
        mis_cnt_d = mis_cnt_q;
        if (ex_valid && (ex_j_type != J_NONE)) begin
            br_cnt_d = br_cnt_q + STAT_W'(1);
        end
        if (res_mis) begin
            mis_cnt_d = mis_cnt_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= '0;
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                ctr_q[i] <= CTR_WN;
            end
        end else begin
            br_cnt_q  <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
            if (wr_en) begin
                valid_q[ex_idx] <= wr_valid_d;
                tag_q[ex_idx]   <= wr_tag_d;
                tgt_q[ex_idx]   <= wr_tgt_d;
                ctr_q[ex_idx]   <= wr_ctr_d;
            end
        end
    end

    assign br_cnt  = br_cnt_q;
    assign mis_cnt = mis_cnt_q;

endmodule

// File: tb/tb_jump_predict_cnt.sv
module tb_jump_predict_cnt;

    localparam int DEPTH = 16;
    localparam int IDX_W = 4;
    localparam int TAG_W = 8;

    localparam logic [1:0] JN = 2'b00, JAL = 2'b01, JALR = 2'b10, JBR = 2'b11;
    localparam logic [1:0] BEQ = 2'b00;

    logic        clk;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic [31:0] if_pred_target;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_target, ex_pred_target;
    logic [1:0]  ex_j_type, ex_branch_t;
    logic        ex_sign, ex_zero, ex_pred_taken;
    logic        flush;
    logic [31:0] next_pc;
    logic [15:0] br_cnt, mis_cnt;

    jump_predict_cnt dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .if_pc          (if_pc),
        .if_pred_taken  (if_pred_taken),
        .if_pred_target (if_pred_target),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_target      (ex_target),
        .ex_j_type      (ex_j_type),
        .ex_branch_t    (ex_branch_t),
        .ex_sign        (ex_sign),
        .ex_zero        (ex_zero),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .flush          (flush),
        .next_pc        (next_pc),
        .br_cnt         (br_cnt),
        .mis_cnt        (mis_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic        flush;
        logic [31:0] npc;
        logic        pt;
        logic [31:0] ptgt;
        logic [15:0] br;
        logic [15:0] mis;
    } obs_t;

    obs_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference table: plain arrays, counter kept as an integer 0..3.
    bit          m_valid [DEPTH];
    int unsigned m_tag   [DEPTH];
    logic [31:0] m_tgt   [DEPTH];
    int          m_ctr   [DEPTH];
    logic [15:0] m_br, m_mis;

    logic [31:0] tgt_set [4] = '{32'h80, 32'h340, 32'h400, 32'h500};

    function automatic int unsigned idx_of(input logic [31:0] pc);
        return (pc >> 2) % DEPTH;
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return (pc >> (IDX_W + 2)) % (1 << TAG_W);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 0;
            m_tgt[i]   = '0;
            m_ctr[i]   = 1;
        end
        m_br  = '0;
        m_mis = '0;
    endtask

    task automatic m_look(input logic [31:0] pc, output logic p, output logic [31:0] t);
        int unsigned i;
        i = idx_of(pc);
        p = m_valid[i] && (m_tag[i] == tag_of(pc)) && (m_ctr[i] >= 2);
        t = p ? m_tgt[i] : 32'h0;
    endtask

    // Drive one cycle, push the expected observation, then advance the model
    // to the state the DUT will hold after the next rising edge.
    task automatic drive(input logic rst, input logic [31:0] ipc, input logic ev,
                         input logic [1:0] jt, input logic [1:0] bt,
                         input logic [31:0] epc, input logic [31:0] etgt,
                         input logic sg, input logic zr,
                         input logic pt, input logic [31:0] ptgt);
        obs_t        e;
        logic        fp, tk, mis;
        logic [31:0] ft;
        int unsigned i;
        @(posedge clk);
        #1;
        rst_n = rst; if_pc = ipc; ex_valid = ev; ex_j_type = jt; ex_branch_t = bt;
        ex_pc = epc; ex_target = etgt; ex_sign = sg; ex_zero = zr;
        ex_pred_taken = pt; ex_pred_target = ptgt;
        if (!rst) m_reset();
        m_look(ipc, fp, ft);
        case (jt)
            JAL, JALR: tk = 1'b1;
            JBR: tk = (bt == 2'b00) ? zr : (bt == 2'b01) ? !zr : (bt == 2'b10) ? sg : !sg;
            default: tk = 1'b0;
        endcase
        mis = ev && ((tk != pt) || (tk && pt && etgt != ptgt) || jt == JALR);
        e.flush = mis;
        e.npc   = mis ? (tk ? etgt : epc + 32'd4) : (fp ? ft : ipc + 32'd4);
        e.pt    = fp;
        e.ptgt  = ft;
        e.br    = m_br;
        e.mis   = m_mis;
        exp_q.push_back(e);
        if (rst && ev) begin
            i = idx_of(epc);
            if (jt != JN) m_br = m_br + 16'd1;
            if (mis) m_mis = m_mis + 16'd1;
            if (jt == JAL) begin
                m_valid[i] = 1'b1; m_tag[i] = tag_of(epc); m_tgt[i] = etgt; m_ctr[i] = 3;
            end else if (jt == JBR) begin
                if (m_valid[i] && m_tag[i] == tag_of(epc)) begin
                    m_ctr[i] = tk ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3)
                                  : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
                    if (tk) m_tgt[i] = etgt;
                end else if (tk) begin
                    m_valid[i] = 1'b1; m_tag[i] = tag_of(epc); m_tgt[i] = etgt; m_ctr[i] = 2;
                end
            end else if (jt == JN && pt) begin
                m_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic idle(input logic [31:0] ipc);
        drive(1'b1, ipc, 1'b0, JN, BEQ, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] rpc();
        return 32'h100 + 32'd4 * $urandom_range(0, 7) + 32'h40 * $urandom_range(0, 2);
    endfunction

    // Monitor: every cycle the DUT presents an observation; pop and compare.
    initial begin : monitor
        obs_t e, a;
        int   cyc;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{flush, next_pc, if_pred_taken, if_pred_target, br_cnt, mis_cnt};
                n_chk++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL sb cycle %0d: got flush=%b npc=%h pt=%b ptgt=%h br=%h mis=%h expected flush=%b npc=%h pt=%b ptgt=%h br=%h mis=%h",
                             cyc, a.flush, a.npc, a.pt, a.ptgt, a.br, a.mis,
                             e.flush, e.npc, e.pt, e.ptgt, e.br, e.mis);
                end
                cyc++;
            end
        end
    end

    initial begin : stim
        logic        pt;
        logic [31:0] ptgt, epc;
        rst_n = 1'b0; if_pc = '0; ex_valid = 1'b0; ex_pc = '0; ex_target = '0;
        ex_j_type = JN; ex_branch_t = BEQ; ex_sign = 1'b0; ex_zero = 1'b0;
        ex_pred_taken = 1'b0; ex_pred_target = '0;
        m_reset();

        // Reset state.
        drive(1'b0, 32'h100, 1'b0, JN, BEQ, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("rst_pred", {31'h0, if_pred_taken}, 32'h0);
        chk("rst_npc", next_pc, 32'h104);
        chk("rst_br", {16'h0, br_cnt}, 32'h0);
        chk("rst_mis", {16'h0, mis_cnt}, 32'h0);
        idle(32'h100);

        // First taken BEQ allocates and redirects.
        drive(1'b1, 32'h300, 1'b1, JBR, BEQ, 32'h100, 32'h80, 1'b0, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        chk("beq_flush", {31'h0, flush}, 32'h1);
        chk("beq_npc", next_pc, 32'h80);
        idle(32'h100);
        @(negedge clk);
        chk("beq_look_pt", {31'h0, if_pred_taken}, 32'h1);
        chk("beq_look_tgt", if_pred_target, 32'h80);

        // Train up, then one not-taken: still predicts taken.
        for (int k = 0; k < 3; k++)
            drive(1'b1, 32'h300, 1'b1, JBR, BEQ, 32'h100, 32'h80, 1'b0, 1'b1, 1'b1, 32'h80);
        drive(1'b1, 32'h300, 1'b1, JBR, BEQ, 32'h100, 32'h80, 1'b0, 1'b0, 1'b1, 32'h80);
        @(negedge clk);
        chk("nt_flush", {31'h0, flush}, 32'h1);
        chk("nt_npc", next_pc, 32'h104);
        idle(32'h100);
        @(negedge clk);
        chk("nt_mis", {16'h0, mis_cnt}, 32'h2);
        chk("nt_still_pt", {31'h0, if_pred_taken}, 32'h1);

        // JALR redirects without allocating.
        drive(1'b1, 32'h300, 1'b1, JALR, BEQ, 32'h200, 32'h340, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("jalr_npc", next_pc, 32'h340);
        idle(32'h200);
        @(negedge clk);
        chk("jalr_noalloc", {31'h0, if_pred_taken}, 32'h0);

        // Alias invalidates the entry.
        drive(1'b1, 32'h300, 1'b1, JN, BEQ, 32'h100, 32'h0, 1'b0, 1'b0, 1'b1, 32'h80);
        @(negedge clk);
        chk("alias_flush", {31'h0, flush}, 32'h1);
        chk("alias_npc", next_pc, 32'h104);
        idle(32'h100);
        @(negedge clk);
        chk("alias_inval", {31'h0, if_pred_taken}, 32'h0);

        // ex_valid low: alias-shaped inputs do nothing.
        drive(1'b1, 32'h300, 1'b0, JN, BEQ, 32'h100, 32'h0, 1'b0, 1'b0, 1'b1, 32'h80);
        @(negedge clk);
        chk("nv_flush", {31'h0, flush}, 32'h0);

        // Same-cycle update and lookup: old state returned.
        drive(1'b1, 32'h1A4, 1'b1, JAL, BEQ, 32'h1A4, 32'h500, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("byp_old", {31'h0, if_pred_taken}, 32'h0);
        idle(32'h1A4);
        @(negedge clk);
        chk("byp_new_tgt", if_pred_target, 32'h500);

        // Reset wins over a concurrent update.
        drive(1'b0, 32'h1C8, 1'b1, JAL, BEQ, 32'h1C8, 32'h400, 1'b0, 1'b0, 1'b0, 32'h0);
        idle(32'h1C8);
        @(negedge clk);
        chk("rst_win", {31'h0, if_pred_taken}, 32'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            epc = rpc();
            if ($urandom_range(0, 9) < 7) m_look(epc, pt, ptgt);
            else begin
                pt   = 1'($urandom);
                ptgt = tgt_set[$urandom_range(0, 3)];
            end
            drive(($urandom_range(0, 59) != 0), rpc(), ($urandom_range(0, 9) != 0),
                  2'($urandom), 2'($urandom), epc, tgt_set[$urandom_range(0, 3)],
                  1'($urandom), 1'($urandom), pt, ptgt);
        end

        // Statistics wrap: not-taken misses never write the table.
        idle(rpc());
        while (m_br != 16'hFFFF)
            drive(1'b1, rpc(), 1'b1, JBR, BEQ, 32'h7F0, 32'h80, 1'b0, 1'b0, 1'b0, 32'h0);
        idle(rpc());
        @(negedge clk);
        chk("br_ffff", {16'h0, br_cnt}, 32'hFFFF);
        drive(1'b1, rpc(), 1'b1, JBR, BEQ, 32'h7F0, 32'h80, 1'b0, 1'b0, 1'b0, 32'h0);
        idle(rpc());
        @(negedge clk);
        chk("br_wrap", {16'h0, br_cnt}, 32'h0);

        repeat (3) @(negedge clk);
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/jump_predict_cnt.md
JUMP_PREDICT_CNT -- requirements
Module: jump_predict_cnt

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/PC width.
REQ-002 SHALL have parameter DEPTH, default 16, number of predictor entries (power of 2, >= 2); IDX_W = log2(DEPTH).
REQ-003 SHALL have parameter TAG_W, default 8, tag bits taken from pc[IDX_W+2 +: TAG_W].
REQ-004 SHALL have parameter STAT_W, default 16, statistics counter width.
REQ-005 clk  in  1  clock, all state updates on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 if_pc  in  XLEN  fetch-stage PC.
REQ-008 if_pred_taken  out  1  fetch prediction: taken.
REQ-009 if_pred_target  out  XLEN  predicted target, 0 when not taken.
REQ-010 ex_valid  in  1  EX stage holds a real instruction.
REQ-011 ex_pc, ex_target  in  XLEN  EX instruction PC and computed jump/branch target.
REQ-012 ex_j_type, ex_branch_t  in  2 each  jump class (00 none, 01 JAL, 10 JALR, 11 BRANCH); branch kind (00 BEQ, 01 BNE, 10 BLT, 11 BGE).
REQ-013 ex_sign, ex_zero  in  1 each  ALU compare sign bit and zero flag.
REQ-014 ex_pred_taken, ex_pred_target  in  1, XLEN  prediction piped from fetch with this instruction.
REQ-015 flush  out  1  kill IF/ID instructions this cycle.
REQ-016 next_pc  out  XLEN  PC to load into fetch register.
REQ-017 br_cnt, mis_cnt  out  STAT_W each  resolved control-flow count, redirect count.

Function
REQ-018 Each entry SHALL hold valid (1b), tag (TAG_W), target (XLEN), 2-bit saturating counter.
REQ-019 Lookup SHALL be combinational on if_pc: index pc[IDX_W+1:2]; if_pred_taken = valid & tag match & counter[1].
REQ-020 Lookup SHALL read registered state only; same-cycle update to the same index SHALL NOT be bypassed.
REQ-021 Outcome taken SHALL be: JAL/JALR 1; BEQ zero; BNE !zero; BLT sign; BGE !sign; none 0.
REQ-022 Mispredict (ex_valid only) SHALL be: taken != ex_pred_taken, or taken & ex_pred_taken & ex_target != ex_pred_target, or JALR always.
REQ-023 On mispredict flush SHALL be 1 combinationally and next_pc SHALL be ex_target if taken, else ex_pc+4.
REQ-024 Without mispredict next_pc SHALL be if_pred_target if if_pred_taken, else if_pc+4; flush 0; EX redirect always overrides fetch prediction.
REQ-025 BRANCH update: hit -> counter +1 if taken (saturate 11), -1 if not (saturate 00), target <= ex_target when taken; miss & taken -> allocate valid, tag, target, counter 10; miss & not taken -> no write.
REQ-026 JAL SHALL allocate/overwrite with counter 11; JALR SHALL NOT write any entry.
REQ-027 ex_j_type 00 with ex_pred_taken 1 (alias) SHALL flush, redirect ex_pc+4, clear valid of that entry.
REQ-028 ex_valid 0 SHALL cause no update, no flush, no count change.
REQ-029 br_cnt SHALL increment per ex_valid cycle with ex_j_type != 00; mis_cnt per mispredict/alias; both wrap modulo 2^STAT_W.

Reset
REQ-030 rst_n low SHALL immediately clear all valid bits, set all counters to 01, clear tags/targets, br_cnt, mis_cnt to 0.
REQ-031 During reset outputs SHALL be: if_pred_taken 0, if_pred_target 0, flush 0 unless EX inputs mispredict (combinational), state unchanged until rst_n high.
REQ-032 Reset asserted mid-update SHALL win; no partial entry write survives.

Structure
REQ-033 Package jump_pkg SHALL hold j_type and branch_t encodings, counter constants (SN 00, WN 01, WT 10, ST 11).
REQ-034 Outcome/mispredict logic SHALL be a combinational sub-module branch_resolve; table and counters stay in jump_predict_cnt.

Verification
REQ-035 Reset then if_pc=0x100 -> if_pred_taken 0, next_pc 0x104, counters 0.
REQ-036 BEQ at ex_pc=0x100, zero=1, pred 0, target 0x80 -> flush 1, next_pc 0x80, entry counter 10; next lookup 0x100 -> taken, target 0x80.
REQ-037 Same BEQ taken 3 more times then not taken once -> counter 11 then 10, prediction still taken, mis_cnt +1 on the not-taken.
REQ-038 JALR at 0x200 target 0x340 with pred 0 -> flush 1, next_pc 0x340, no entry allocated at 0x200.
REQ-039 Alias: ex_j_type 00, ex_pred_taken 1 at 0x100 -> flush 1, next_pc 0x104, entry invalidated.
REQ-040 Update and lookup same index same cycle -> old prediction returned; br_cnt wraps 0xFFFF -> 0x0000 with STAT_W 16.
